keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Parametrised keyboard-matrix scanner with per-key debounce and a valid/ready key-event output. Drives one active-low row at a time, samples all columns after a programmable settle interval, debounces every key independently, and emits press/release events in row-major order. Sits between the keyboard pins and the key-decode/display logic, clocked from `clk_50`.

## Interface
- `ROWS`, 4, number of matrix rows driven.
- `COLS`, 4, number of matrix columns sampled.
- `SCAN_DIV`, 1000, `clk_50` cycles a row is driven before sampling; must be ≥2.
- `DEBOUNCE`, 4, consecutive differing samples needed to flip a key; must be ≥1.
- `CODE_W`, `$clog2(ROWS*COLS)`, key code width.
- `clk_50`  in  1  system clock, the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `COL`  in  COLS  column inputs, pulled up; low = key pressed on the driven row.
- `ROW`  out  ROWS  row drive, active-low one-hot; all-ones = no row driven.
- `key_valid`  out  1  event available.
- `key_ready`  in  1  consumer accepts event when high with `key_valid`.
- `key_code`  out  CODE_W  `row*COLS + col`.
- `key_press`  out  1  1 = press, 0 = release.
- `key_state`  out  ROWS*COLS  debounced state, bit `row*COLS+col`, 1 = pressed.
- `key_down`  out  1  OR of `key_state`.

## Operation
- Reset values: `ROW`=all-ones, `key_valid`=0, `key_code`=0, `key_press`=0, `key_state`=0, `key_down`=0; row index r=0, all debounce counters and change flags 0, FSM in DRIVE.
- FSM DRIVE: `ROW` registered to `~(1<<r)` on the first edge in DRIVE; settle counter cleared on entry, counts to SCAN_DIV-1, then → SAMPLE.
- SAMPLE (1 cycle): for each column c, raw = ~`COL[c]`. If raw ≠ stable bit: counter+1; on the DEBOUNCE-th consecutive differing sample the stable bit flips, counter clears, change flag sets. If raw = stable: counter clears. → EMIT, c=0.
- EMIT: one column per cycle. Flag clear → advance. Flag set → `key_valid`=1 with code/press; advance and clear flag only on the cycle `key_valid & key_ready`. After column COLS-1 accepted/skipped: r ← r+1, wrapping ROWS-1 → 0; → DRIVE.
- `ROW` never changes while in SAMPLE or EMIT; back-pressure stalls the scan, it never drops events.
- `key_state`/`key_down` update in SAMPLE, before the event is emitted.
- Multiple changes: ascending column within a row, ascending row across rows. No ghost rejection.
- Counter width `$clog2(DEBOUNCE)+1`; DEBOUNCE=1 flips on the first differing sample.

## Timing
- Row period with `key_ready` held high: SCAN_DIV + 1 + COLS cycles, independent of event count.
- Each stalled cycle (`key_valid` & !`key_ready`) adds one cycle to the row period.
- Event latency: `key_valid` asserts the cycle after SAMPLE plus c cycles, for column c.
- `key_code`/`key_press` stable while `key_valid` high; `key_valid` drops the cycle after acceptance unless the next column also has an event (back-to-back allowed).
- Reset mid-operation: any pending event is discarded; outputs reach reset values on the next edge; scanning restarts at row 0.
- `COL` is sampled directly; synchronising metastable pins is the top level's job.

## Configuration
- `KEYSCAN_RELEASE_EN` defined: releases set the change flag and emit events with `key_press`=0.
- Undefined: releases update `key_state` only; no change flag, no event; `key_press` is constant 1.

## Test plan
Bench parameters: ROWS=4, COLS=4, SCAN_DIV=8, DEBOUNCE=3, `key_ready`=1 unless stated.
- Reset, no keys → `ROW` 1111 during reset; then 1110, 1101, 1011, 0111, 1110…, each held 13 cycles; `key_valid` never 1.
- Hold row 1/col 2 (`COL[2]` low while `ROW`=1101) → on the 3rd row-1 SAMPLE, `key_state[6]`=1, `key_down`=1; next cycle is column 0, event code 6 / press 1 appears 2 cycles later for 1 cycle.
- Bounce row 1/col 2 pressed for 2 row-1 scans, then released → no event; `key_state`=0.
- Rows 2 col 0 and col 3 pressed, `key_ready`=0 → `key_valid`=1 code 8 held, `ROW`=1011 held; raise ready → code 8 accepted, then code 11; row 3 driven afterwards.
- Release held key 6 for 3 scans → with `KEYSCAN_RELEASE_EN`, event code 6 press 0; without it, no event, `key_state[6]` clears.
- Assert `rst` while code 8 is stalled → next edge: `key_valid`=0, `key_state`=0, `ROW`=1111; scanning resumes at row 0.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: row-scanning keyboard-matrix controller with per-key debounce and valid/ready key events
// Ports:
//   clk_50     system clock (only clock)
//   rst        synchronous active-high reset
//   COL        column inputs, pulled up, low = key pressed on the driven row
//   ROW        active-low one-hot row drive, all-ones = no row driven
//   key_valid  event available
//   key_ready  consumer accepts the event when high together with key_valid
//   key_code   row*COLS + col of the event
//   key_press  1 = press, 0 = release
//   key_state  debounced state, bit row*COLS+col, 1 = pressed
//   key_down   OR of key_state
// Build option: define KEYSCAN_RELEASE_EN to report releases as events (key_press=0);
// otherwise releases only update key_state and key_press is tied to 1.
module keypad_scan_ctrl #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4,
    parameter int CODE_W   = $clog2(ROWS*COLS)
) (
    input  logic                 clk_50,
    input  logic                 rst,
    input  logic [COLS-1:0]      COL,
    output logic [ROWS-1:0]      ROW,
    output logic                 key_valid,
    input  logic                 key_ready,
    output logic [CODE_W-1:0]    key_code,
    output logic                 key_press,
    output logic [ROWS*COLS-1:0] key_state,
    output logic                 key_down
);
    localparam int N  = ROWS * COLS;
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE) + 1;

    localparam logic [1:0] DRIVE  = 2'd0;
    localparam logic [1:0] SAMPLE = 2'd1;
    localparam logic [1:0] EMIT   = 2'd2;

    logic [1:0]    state;
    logic [SW-1:0] settle;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic [N-1:0]  flag;
    logic          accept;
    logic          advance;

`ifdef KEYSCAN_RELEASE_EN
    localparam bit REL = 1'b1;
    // key_state already holds the post-flip value, so it is the press/release direction
    assign key_press = key_state[key_code];
`else
    localparam bit REL = 1'b0;
    assign key_press = 1'b1;
`endif

    assign key_code  = CODE_W'(int'(r) * COLS + int'(c));
    assign key_valid = (state == EMIT) && flag[key_code];
    assign accept    = key_valid && key_ready;
    // a column without a pending event is skipped; one with an event waits for ready
    assign advance   = (state == EMIT) && (!flag[key_code] || key_ready);
    assign key_down  = |key_state;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state  <= DRIVE;
            settle <= '0;
            r      <= '0;
            c      <= '0;
            ROW    <= '1;
        end else if (state == DRIVE) begin
            ROW    <= ~(ROWS'(1) << r);
            settle <= settle + 1'b1;
            if (settle == SW'(SCAN_DIV - 1)) begin
                settle <= '0;
                state  <= SAMPLE;
            end
        end else if (state == SAMPLE) begin
            state <= EMIT;
            c     <= '0;
        end else if (advance) begin
            if (c == CW'(COLS - 1)) begin
                c     <= '0;
                state <= DRIVE;
                r     <= (r == RW'(ROWS - 1)) ? '0 : r + 1'b1;
            end else begin
                c <= c + 1'b1;
            end
        end else if (state != EMIT) begin
            state <= DRIVE;
        end
    end

    genvar k;
    for (k = 0; k < N; k++) begin : g_key
        localparam int KR = k / COLS;
        localparam int KC = k % COLS;
        logic [DW-1:0] cnt;
        logic          st;
        logic          fl;
        assign key_state[k] = st;
        assign flag[k]      = fl;
        always_ff @(posedge clk_50) begin
            if (rst) begin
                cnt <= '0;
                st  <= 1'b0;
                fl  <= 1'b0;
            end else if (state == SAMPLE && r == RW'(KR)) begin
                // raw = ~COL differs from the stable bit exactly when COL equals it
                if (COL[KC] == st) begin
                    cnt <= (cnt == DW'(DEBOUNCE - 1)) ? '0 : cnt + 1'b1;
                    if (cnt == DW'(DEBOUNCE - 1)) begin
                        st <= ~st;
                        fl <= REL | ~st;
                    end
                end else begin
                    cnt <= '0;
                end
            end else if (accept && key_code == CODE_W'(k)) begin
                fl <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: randomized self-checking bench for keypad_scan_ctrl against a behavioural keypad/scan model
module tb_keypad_scan_ctrl;
    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 8;
    localparam int DEBOUNCE = 3;
    localparam int N        = ROWS * COLS;
    localparam int CODE_W   = 4;
`ifdef KEYSCAN_RELEASE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic              clk_50 = 1'b0;
    logic              rst = 1'b1;
    logic              key_ready = 1'b1;
    logic [COLS-1:0]   col;
    logic [ROWS-1:0]   row;
    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              key_press;
    logic [N-1:0]      key_state;
    logic              key_down;
    logic [N-1:0]      pressed = '0;

    int n_pass = 0;
    int n_chk  = 0;

    // reference model: position in the current row scan, stalls so far, debounced keys, pending events
    int            pc, st, mrow;
    logic [ROWS-1:0] exp_row;
    logic [N-1:0]  ks;
    int            dcnt [N];
    logic [COLS-1:0] ev, evp;
    bit            was_rst = 1'b1;

    keypad_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .CODE_W(CODE_W)
    ) dut (
        .clk_50(clk_50), .rst(rst), .COL(col), .ROW(row),
        .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
        .key_press(key_press), .key_state(key_state), .key_down(key_down)
    );

    always #5 clk_50 = ~clk_50;

    // physical matrix: a pressed key pulls its column low while its row is driven low
    always_comb begin
        col = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!row[r] && pressed[r*COLS+c]) col[c] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        pc = 0; st = 0; mrow = 0;
        exp_row = '1; ks = '0; ev = '0; evp = '0;
        for (int k = 0; k < N; k++) dcnt[k] = 0;
    endtask

    // advance the model across one clock edge given the inputs applied for it
    task automatic model_step(input bit r, input bit rdy);
        int ci;
        int k;
        was_rst = r;
        if (r) begin
            model_reset();
            return;
        end
        if (pc == 0) exp_row = ~(ROWS'(1) << mrow);
        if (pc == SCAN_DIV) begin
            for (int c = 0; c < COLS; c++) begin
                k = mrow * COLS + c;
                if (pressed[k] != ks[k]) begin
                    dcnt[k]++;
                    if (dcnt[k] == DEBOUNCE) begin
                        ks[k] = pressed[k];
                        dcnt[k] = 0;
                        if (pressed[k] || REL) begin
                            ev[c] = 1'b1;
                            evp[c] = pressed[k];
                        end
                    end
                end else begin
                    dcnt[k] = 0;
                end
            end
        end
        if (pc > SCAN_DIV) begin
            ci = pc - SCAN_DIV - 1 - st;
            if (ev[ci] && !rdy) begin
                st++;
            end else begin
                ev[ci] = 1'b0;
                if (ci == COLS - 1) begin
                    mrow = (mrow + 1) % ROWS;
                    pc = 0;
                    st = 0;
                    return;
                end
            end
        end
        pc++;
    endtask

    task automatic compare_cycle();
        int ci;
        check("ROW", 32'(row), 32'(exp_row));
        check("key_state", 32'(key_state), 32'(ks));
        check("key_down", 32'(key_down), 32'(|ks));
        ci = pc - SCAN_DIV - 1 - st;
        if (pc > SCAN_DIV) begin
            check("key_valid", 32'(key_valid), 32'(ev[ci]));
            if (ev[ci]) begin
                check("key_code", 32'(key_code), 32'(mrow * COLS + ci));
                check("key_press", 32'(key_press), 32'(evp[ci]));
            end
        end else begin
            check("key_valid_idle", 32'(key_valid), 0);
        end
        if (was_rst) check("key_code_rst", 32'(key_code), 0);
    endtask

    task automatic tick(input bit r, input bit rdy, input logic [N-1:0] keys);
        @(negedge clk_50);
        compare_cycle();
        rst = r;
        key_ready = rdy;
        pressed = keys;
        model_step(r, rdy);
    endtask

    initial begin
        logic [N-1:0] keys;
        logic [N-1:0] k8_11;
        int len;
        model_reset();
        k8_11 = '0;
        k8_11[8] = 1'b1;
        k8_11[11] = 1'b1;
        repeat (3) tick(1'b1, 1'b1, '0);
        repeat (60) tick(1'b0, 1'b1, '0);
        repeat (200) tick(1'b0, 1'b1, N'(1) << 6);
        repeat (200) tick(1'b0, 1'b1, '0);
        repeat (90) tick(1'b0, 1'b1, N'(1) << 6);
        repeat (200) tick(1'b0, 1'b1, '0);
        repeat (250) tick(1'b0, 1'b0, k8_11);
        repeat (100) tick(1'b0, 1'b1, k8_11);
        repeat (250) tick(1'b0, 1'b1, '0);
        repeat (250) tick(1'b0, 1'b0, k8_11);
        tick(1'b1, 1'b0, k8_11);
        repeat (250) tick(1'b0, 1'b1, k8_11);
        repeat (250) tick(1'b0, 1'b1, '0);
        for (int p = 0; p < 40; p++) begin
            keys = N'($urandom & $urandom & $urandom);
            len = $urandom_range(300, 20);
            for (int i = 0; i < len; i++)
                tick($urandom_range(999, 0) == 0, $urandom_range(3, 0) != 0, keys);
        end
        tick(1'b0, 1'b1, '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
